// File: rtl/ex_hilo_pkg.sv
// ex_hilo_pkg -- shared types and constants for the EX-stage HI/LO controller.
//
// Contents:
//   hilo_op_t     operation code presented by EX (4 bits)
//   hilo_state_t  controller FSM state
//   MULT_*        multiplier command encodings
//   is_mult_class / is_signed_op  opcode decode helpers
//
// Build option: HILO_ACC_EN -- when defined, MADD/MADDU/MSUB/MSUBU decode as
// multiplier-class ops; when undefined they decode as NOP.

package ex_hilo_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    MTHI  = 4'd3,
    MTLO  = 4'd4,
    MADD  = 4'd5,
    MADDU = 4'd6,
    MSUB  = 4'd7,
    MSUBU = 4'd8
  } hilo_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ACC    = 3'd3,
    DRAIN  = 3'd4
  } hilo_state_t;

  localparam logic [1:0] MULT_IDLE     = 2'b00;
  localparam logic [1:0] MULT_SIGNED   = 2'b10;
  localparam logic [1:0] MULT_UNSIGNED = 2'b01;

  // Ops that occupy the multiplier and therefore stall the pipeline.
  function automatic logic is_mult_class(input hilo_op_t o);
    case (o)
      MULT, MULTU: return 1'b1;
`ifdef HILO_ACC_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input hilo_op_t o);
    return (o == MULT) || (o == MADD) || (o == MSUB);
  endfunction

endpackage

// File: rtl/ex_hilo_ctrl_acc64.sv
// hilo_acc64 -- registered 64-bit add/subtract used by the accumulate ops.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   async active-low reset
//   en     in   1   capture a new result this edge
//   sub    in   1   1: acc - prod, 0: acc + prod
//   acc    in   64  current {HI,LO}
//   prod   in   64  multiplier product
//   sum    out  64  registered result (mod 2^64)
//
// Only instantiated when HILO_ACC_EN is defined.

module hilo_acc64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sub,
  input  logic [63:0] acc,
  input  logic [63:0] prod,
  output logic [63:0] sum
);

  logic [63:0] sum_reg;

  // Plain modular arithmetic: the product's signedness is already encoded
  // in its 64-bit two's-complement pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
    end else if (en) begin
      sum_reg <= sub ? (acc - prod) : (acc + prod);
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/ex_hilo_ctrl.sv
// ex_hilo_ctrl -- EX-stage HI/LO controller wrapped around a 4-cycle multiplier.
//
// Accepts MULT/MULTU/MTHI/MTLO (and MADD/MADDU/MSUB/MSUBU when HILO_ACC_EN is
// defined), launches the multiplier, waits for its done flag and writes the
// 64-bit result into HI/LO. Stalls the pipeline while busy and forwards MTHI/MTLO
// data to the hi/lo outputs in the accept cycle.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   async active-low reset
//   op_valid   in   1   EX presents an op this cycle
//   op         in   4   hilo_op_t
//   rs_val     in   32  operand A / MTHI,MTLO source
//   rt_val     in   32  operand B
//   flush      in   1   squash in-flight or presented op; HI/LO untouched
//   busy       out  1   stall request
//   hi, lo     out  32  architectural HI/LO with forwarding
//   mult_op    out  2   multiplier command: 10 signed, 01 unsigned, 00 idle
//   mult_a/b   out  32  multiplier operands
//   mult_c     in   64  multiplier product
//   mult_done  in   1   multiplier idle / result valid
//
// Build option: HILO_ACC_EN enables the accumulate ops, the ACC state and the
// hilo_acc64 adder.

module ex_hilo_ctrl
  import ex_hilo_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  mult_op,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_c,
  input  logic        mult_done
);

  hilo_state_t state_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [3:0]  wait_cnt_reg;

  hilo_op_t op_e;
  logic     op_is_mult;
  logic     accept;
  logic     accept_mult;

  assign op_e        = hilo_op_t'(op);
  assign op_is_mult  = is_mult_class(op_e);
  assign accept      = op_valid && (state_reg == IDLE) && !flush;
  assign accept_mult = accept && op_is_mult;

  // The multiplier is started combinationally in the accept cycle so that it
  // captures the operands on the same edge the FSM moves to LAUNCH.
  assign mult_op = accept_mult ? (is_signed_op(op_e) ? MULT_SIGNED : MULT_UNSIGNED)
                               : MULT_IDLE;
  assign mult_a  = accept_mult ? rs_val : '0;
  assign mult_b  = accept_mult ? rt_val : '0;

  // Stall is raised in the presentation cycle itself, before the FSM moves.
  assign busy = (state_reg != IDLE) || (op_valid && op_is_mult && (state_reg == IDLE));

  // MTHI/MTLO results are visible to an MFHI/MFLO in the same cycle.
  assign hi = (accept && (op_e == MTHI)) ? rs_val : hi_reg;
  assign lo = (accept && (op_e == MTLO)) ? rs_val : lo_reg;

`ifdef HILO_ACC_EN
  logic        acc_reg;
  logic        sub_reg;
  logic        acc_en;
  logic [63:0] acc_sum;

  // The sum is formed on the same edge that would otherwise write the raw
  // product, so ACC only has to copy it into HI/LO.
  assign acc_en = (state_reg == WAIT) && mult_done && !flush && acc_reg;

  hilo_acc64 u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (acc_en),
    .sub  (sub_reg),
    .acc  ({hi_reg, lo_reg}),
    .prod (mult_c),
    .sum  (acc_sum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hi_reg       <= '0;
      lo_reg       <= '0;
      wait_cnt_reg <= '0;
`ifdef HILO_ACC_EN
      acc_reg      <= 1'b0;
      sub_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (op_e == MTHI) begin
              hi_reg <= rs_val;
            end else if (op_e == MTLO) begin
              lo_reg <= rs_val;
            end else if (op_is_mult) begin
`ifdef HILO_ACC_EN
              acc_reg <= (op_e == MADD) || (op_e == MADDU) ||
                         (op_e == MSUB) || (op_e == MSUBU);
              sub_reg <= (op_e == MSUB) || (op_e == MSUBU);
`endif
              state_reg <= LAUNCH;
            end
          end
        end
        // mult_done may still show the pre-launch idle value here.
        LAUNCH: state_reg <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (flush) begin
            state_reg <= DRAIN;
          end else if (mult_done) begin
`ifdef HILO_ACC_EN
            if (acc_reg) begin
              state_reg <= ACC;
            end else begin
              {hi_reg, lo_reg} <= mult_c;
              state_reg        <= IDLE;
            end
`else
            {hi_reg, lo_reg} <= mult_c;
            state_reg        <= IDLE;
`endif
          end
        end
`ifdef HILO_ACC_EN
        ACC: begin
          if (flush) begin
            state_reg <= DRAIN;
          end else begin
            {hi_reg, lo_reg} <= acc_sum;
            state_reg        <= IDLE;
          end
        end
`endif
        // The multiplier cannot be aborted; hold the stall until it is idle.
        DRAIN: if (mult_done) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // Cycles spent waiting on the multiplier, saturating.
      if ((state_reg == WAIT) || (state_reg == DRAIN)) begin
        if (wait_cnt_reg != 4'hF) wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  // A multiplier of depth MULT_LAT must report done within MULT_LAT waiting cycles.
  a_wait_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(wait_cnt_reg) <= MULT_LAT);

endmodule
